// File: rtl/dram_arbiter_if.sv
// -----------------------------------------------------------------------------
// dram_arbiter_if
// Bundles every bus signal around the DRAM arbiter: the two requester ports
// (core = port 0, image I/O = port 1) and the single-port RAM side.
//
//   slave  : the arbiter. It takes requests and RAM read data, and it drives
//            grants, read-valid strobes, read data and the RAM command.
//   master : the surrounding system, meaning the requesters plus the RAM.
//            It drives requests and mem_dout, and it observes everything else.
//
// Signals
//   req0/1, we0/1, addr0/1, wdata0/1 : per-port request, write flag, address, data
//   gnt0/1                           : access issued this cycle
//   rvalid0/1, rdata0/1              : read return strobe and data
//   mem_addr, mem_read, mem_write,
//   mem_din, mem_dout                : RAM command and data
// -----------------------------------------------------------------------------
interface dram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_read, mem_write, mem_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_read, mem_write, mem_din
  );
endinterface

// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
// Shares one single-port AW x DW RAM between two requesters.
// Port 0 is the processor core. Port 1 is the image I/O unit.
//
// Arbitration is round-robin with a burst limit. An owner keeps the RAM for
// up to MAX_BURST consecutive grants while the other port is requesting.
// Grants are combinational. A request is therefore issued in the cycle it
// is presented, and back-to-back grants sustain one access per clock.
//
// Reads are tracked in a RD_LATENCY-deep {valid, port} shift register. The
// matching rvalid pulses exactly when the RAM's registered mem_dout carries
// the data for that read.
//
// Ports
//   clk  : system clock, all logic on posedge
//   rst  : synchronous reset, active-high
//   bus  : dram_arbiter_if.slave (requester ports + RAM command/data)
// -----------------------------------------------------------------------------
module dram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int MAX_BURST  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  dram_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  // Burst counter increment that saturates at the burst limit.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    if (cnt < CNT_MAX) begin
      return cnt + CNT_ONE;
    end else begin
      return CNT_MAX;
    end
  endfunction

  logic [1:0]          state_r;
  logic [1:0]          state_s;
  logic [CW-1:0]       burst_cnt_r;
  logic [CW-1:0]       burst_cnt_s;
  logic                last_r;
  logic                last_s;
  logic                gnt0_s;
  logic                gnt1_s;

  logic [AW-1:0]       mem_addr_s;
  logic [DW-1:0]       mem_din_s;
  logic                mem_read_s;
  logic                mem_write_s;

  logic                rd_issue_s;
  logic [RD_LATENCY-1:0] pipe_valid_r;
  logic [RD_LATENCY-1:0] pipe_port_r;
  logic [RD_LATENCY-1:0] pipe_valid_s;
  logic [RD_LATENCY-1:0] pipe_port_s;

  // Arbitration: choose this cycle's grant and the next owner/burst/last state.
  always_comb begin
    state_s     = state_r;
    burst_cnt_s = burst_cnt_r;
    last_s      = last_r;
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    if (rst) begin
      state_s     = IDLE;
      burst_cnt_s = CNT_ZERO;
      last_s      = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          // On a tie, the port that did not own the RAM most recently wins.
          if (bus.req0 && bus.req1) begin
            if (last_r) begin
              gnt0_s  = 1'b1;
              state_s = OWN0;
            end else begin
              gnt1_s  = 1'b1;
              state_s = OWN1;
            end
            burst_cnt_s = CNT_ONE;
          end else if (bus.req0) begin
            gnt0_s      = 1'b1;
            state_s     = OWN0;
            burst_cnt_s = CNT_ONE;
          end else if (bus.req1) begin
            gnt1_s      = 1'b1;
            state_s     = OWN1;
            burst_cnt_s = CNT_ONE;
          end else begin
            state_s     = IDLE;
          end
        end
        OWN0: begin
          if (bus.req0 && (!bus.req1 || (burst_cnt_r < CNT_MAX))) begin
            gnt0_s      = 1'b1;
            burst_cnt_s = sat_inc(burst_cnt_r);
          end else if (bus.req1) begin
            gnt1_s      = 1'b1;
            state_s     = OWN1;
            burst_cnt_s = CNT_ONE;
            last_s      = 1'b0;
          end else begin
            state_s     = IDLE;
            burst_cnt_s = CNT_ZERO;
            last_s      = 1'b0;
          end
        end
        OWN1: begin
          if (bus.req1 && (!bus.req0 || (burst_cnt_r < CNT_MAX))) begin
            gnt1_s      = 1'b1;
            burst_cnt_s = sat_inc(burst_cnt_r);
          end else if (bus.req0) begin
            gnt0_s      = 1'b1;
            state_s     = OWN0;
            burst_cnt_s = CNT_ONE;
            last_s      = 1'b1;
          end else begin
            state_s     = IDLE;
            burst_cnt_s = CNT_ZERO;
            last_s      = 1'b1;
          end
        end
        default: begin
          state_s     = IDLE;
          burst_cnt_s = CNT_ZERO;
          last_s      = 1'b1;
        end
      endcase
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      burst_cnt_r <= CNT_ZERO;
      last_r      <= 1'b1;
    end else begin
      state_r     <= state_s;
      burst_cnt_r <= burst_cnt_s;
      last_r      <= last_s;
    end
  end

  // RAM command mux: route the granted port straight to the RAM in the same cycle.
  always_comb begin
    mem_addr_s  = {AW{1'b0}};
    mem_din_s   = {DW{1'b0}};
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    if (gnt0_s) begin
      mem_addr_s  = bus.addr0;
      mem_din_s   = bus.wdata0;
      mem_read_s  = ~bus.we0;
      mem_write_s = bus.we0;
    end else if (gnt1_s) begin
      mem_addr_s  = bus.addr1;
      mem_din_s   = bus.wdata1;
      mem_read_s  = ~bus.we1;
      mem_write_s = bus.we1;
    end else begin
      mem_addr_s  = {AW{1'b0}};
      mem_din_s   = {DW{1'b0}};
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
    end
  end

  // Only reads enter the return pipeline. The port bit is 1 for port 1.
  assign rd_issue_s = mem_read_s;

  // Stage 0 takes the new entry and the older entries shift toward the output.
  // A depth of 1 has nothing to shift, so it gets its own branch.
  if (RD_LATENCY > 1) begin : g_pipe_deep
    assign pipe_valid_s = {pipe_valid_r[RD_LATENCY-2:0], rd_issue_s};
    assign pipe_port_s  = {pipe_port_r[RD_LATENCY-2:0], gnt1_s};
  end else begin : g_pipe_single
    assign pipe_valid_s = rd_issue_s;
    assign pipe_port_s  = gnt1_s;
  end

  // Read-return pipeline. Reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_r <= {RD_LATENCY{1'b0}};
      pipe_port_r  <= {RD_LATENCY{1'b0}};
    end else begin
      pipe_valid_r <= pipe_valid_s;
      pipe_port_r  <= pipe_port_s;
    end
  end

  assign bus.gnt0      = gnt0_s;
  assign bus.gnt1      = gnt1_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_din   = mem_din_s;
  assign bus.mem_read  = mem_read_s;
  assign bus.mem_write = mem_write_s;

  // The pipeline still holds its last entry during the reset cycle.
  // Gating with rst keeps a read issued just before reset from returning.
  assign bus.rvalid0 = pipe_valid_r[RD_LATENCY-1] & ~pipe_port_r[RD_LATENCY-1] & ~rst;
  assign bus.rvalid1 = pipe_valid_r[RD_LATENCY-1] &  pipe_port_r[RD_LATENCY-1] & ~rst;
  assign bus.rdata0  = bus.mem_dout;
  assign bus.rdata1  = bus.mem_dout;

endmodule

// File: tb/tb_dram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_arbiter
// Directed self-checking bench for dram_arbiter. There are two instances:
//   dut_a : RD_LATENCY=1 (reset, single port, contention, yield, reset mid-flight)
//   dut_b : RD_LATENCY=3 (latency and in-order returns)
// Each instance has a behavioural RAM whose registered read data arrives
// RD_LATENCY cycles after the read is issued.
// Inputs are driven 1 ns after posedge. Outputs are sampled 2 ns later.
// -----------------------------------------------------------------------------
module tb_dram_arbiter;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  dram_arbiter_if #(.AW(16), .DW(8)) ifa ();
  dram_arbiter_if #(.AW(16), .DW(8)) ifb ();

  dram_arbiter #(.AW(16), .DW(8), .MAX_BURST(4), .RD_LATENCY(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  dram_arbiter #(.AW(16), .DW(8), .MAX_BURST(4), .RD_LATENCY(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];
  logic [7:0] b_d1;
  logic [7:0] b_d2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model for dut_a: one-cycle registered read data.
  always @(posedge clk) begin
    if (ifa.mem_write) mem_a[ifa.mem_addr] <= ifa.mem_din;
    if (ifa.mem_read)  ifa.mem_dout <= mem_a[ifa.mem_addr];
  end

  // RAM model for dut_b: three-cycle registered read data.
  always @(posedge clk) begin
    if (ifb.mem_write) mem_b[ifb.mem_addr] <= ifb.mem_din;
    if (ifb.mem_read)  b_d1 <= mem_b[ifb.mem_addr];
    b_d2         <= b_d1;
    ifb.mem_dout <= b_d2;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.we0 = 1'b0; ifa.we1 = 1'b0;
    ifa.addr0 = 16'h0000; ifa.addr1 = 16'h0000; ifa.wdata0 = 8'h00; ifa.wdata1 = 8'h00;
    ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.we0 = 1'b0; ifb.we1 = 1'b0;
    ifb.addr0 = 16'h0000; ifb.addr1 = 16'h0000; ifb.wdata0 = 8'h00; ifb.wdata1 = 8'h00;
  endtask

  logic [1:0] exp_g;
  logic [1:0] prev_g;

  initial begin
    rst = 1'b1;
    idle_inputs();
    ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    ifb.req0 = 1'b1; ifb.req1 = 1'b1;
    tick();

    // 1: reset held two cycles with both ports requesting
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq("rst_a_ctl", {ifa.gnt0, ifa.gnt1, ifa.rvalid0, ifa.rvalid1, ifa.mem_read, ifa.mem_write}, 6'b000000);
      check_eq("rst_a_addr", {8'h00, ifa.mem_addr, ifa.mem_din}, 32'h0000_0000);
      check_eq("rst_b_ctl", {ifb.gnt0, ifb.gnt1, ifb.rvalid0, ifb.rvalid1, ifb.mem_read, ifb.mem_write}, 6'b000000);
      tick();
    end

    // 3: contention, both ports read continuously for 12 cycles
    rst = 1'b0;
    idle_inputs();
    ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    ifa.addr0 = 16'h0300; ifa.addr1 = 16'h0301;
    prev_g = 2'b00;
    for (int i = 0; i < 12; i++) begin
      settle();
      exp_g = ((i < 4) || (i >= 8)) ? 2'b10 : 2'b01;
      check_eq($sformatf("cont_gnt[%0d]", i), {ifa.gnt0, ifa.gnt1}, exp_g);
      check_eq($sformatf("cont_rvalid[%0d]", i), {ifa.rvalid0, ifa.rvalid1}, prev_g);
      prev_g = exp_g;
      tick();
    end
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;
    settle();
    check_eq("cont_drop_gnt", {ifa.gnt0, ifa.gnt1}, 2'b00);
    check_eq("cont_last_rvalid", {ifa.rvalid0, ifa.rvalid1}, 2'b10);
    tick();

    // 2: port 0 writes 0xA5 @0x0010, then reads it back
    ifa.req0 = 1'b1; ifa.we0 = 1'b1; ifa.addr0 = 16'h0010; ifa.wdata0 = 8'hA5;
    settle();
    check_eq("wr_gnt", {ifa.gnt0, ifa.gnt1}, 2'b10);
    check_eq("wr_strobes", {ifa.mem_read, ifa.mem_write}, 2'b01);
    check_eq("wr_addr_din", {8'h00, ifa.mem_addr, ifa.mem_din}, 32'h0000_10A5);
    tick();
    ifa.we0 = 1'b0;
    settle();
    check_eq("rd_gnt", {ifa.gnt0, ifa.gnt1}, 2'b10);
    check_eq("rd_strobes", {ifa.mem_read, ifa.mem_write}, 2'b10);
    check_eq("wr_no_rvalid", {ifa.rvalid0, ifa.rvalid1}, 2'b00);
    tick();
    ifa.req0 = 1'b0;
    settle();
    check_eq("rd_rvalid", {ifa.rvalid0, ifa.rvalid1}, 2'b10);
    check_eq("rd_rdata0", {24'h0, ifa.rdata0}, 32'h0000_00A5);
    tick();
    settle();
    check_eq("rd_rvalid_once", {ifa.rvalid0, ifa.rvalid1}, 2'b00);

    // 4a: port 1 owns with burst 2, then hands over to a waiting port 0 in the same cycle
    ifa.req1 = 1'b1; ifa.we1 = 1'b1; ifa.addr1 = 16'h0400; ifa.wdata1 = 8'h77;
    settle();
    check_eq("yield_p1_first", {ifa.gnt0, ifa.gnt1}, 2'b01);
    tick();
    settle();
    check_eq("yield_p1_second", {ifa.gnt0, ifa.gnt1}, 2'b01);
    tick();
    ifa.req1 = 1'b0;
    ifa.req0 = 1'b1; ifa.we0 = 1'b1; ifa.addr0 = 16'h0401;
    settle();
    check_eq("yield_to_p0", {ifa.gnt0, ifa.gnt1}, 2'b10);
    tick();
    ifa.req0 = 1'b0;
    settle();
    check_eq("yield_release", {ifa.gnt0, ifa.gnt1}, 2'b00);
    tick();

    // 4b: port 1 drops with nobody waiting, so the arbiter goes to IDLE with last=1,
    //     and a later tie goes to port 0
    ifa.req1 = 1'b1;
    settle();
    check_eq("idle_p1_first", {ifa.gnt0, ifa.gnt1}, 2'b01);
    tick();
    settle();
    check_eq("idle_p1_second", {ifa.gnt0, ifa.gnt1}, 2'b01);
    tick();
    ifa.req1 = 1'b0;
    settle();
    check_eq("idle_none", {ifa.gnt0, ifa.gnt1}, 2'b00);
    tick();
    ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    settle();
    check_eq("idle_tie_p0", {ifa.gnt0, ifa.gnt1}, 2'b10);
    tick();
    ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.we0 = 1'b0; ifa.we1 = 1'b0;
    tick();

    // 6: read granted, reset on the next cycle, so the read never returns
    ifa.req0 = 1'b1; ifa.addr0 = 16'h0010;
    settle();
    check_eq("mid_rd_gnt", {ifa.gnt0, ifa.gnt1}, 2'b10);
    tick();
    ifa.req0 = 1'b0;
    rst = 1'b1;
    settle();
    check_eq("mid_rst_rvalid", {ifa.rvalid0, ifa.rvalid1}, 2'b00);
    tick();
    rst = 1'b0;
    settle();
    check_eq("mid_after_rvalid", {ifa.rvalid0, ifa.rvalid1}, 2'b00);
    tick();
    settle();
    check_eq("mid_after2_rvalid", {ifa.rvalid0, ifa.rvalid1}, 2'b00);
    tick();

    // 5: dut_b, with RD_LATENCY=3. First load the RAM through port 0.
    ifb.req0 = 1'b1; ifb.we0 = 1'b1; ifb.addr0 = 16'hFFFF; ifb.wdata0 = 8'h3C;
    settle();
    check_eq("lat_wr0_gnt", {ifb.gnt0, ifb.gnt1}, 2'b10);
    tick();
    ifb.addr0 = 16'h0100; ifb.wdata0 = 8'h11;
    tick();
    ifb.addr0 = 16'h0101; ifb.wdata0 = 8'h22;
    tick();
    ifb.req0 = 1'b0; ifb.we0 = 1'b0;
    tick();
    ifb.req1 = 1'b1; ifb.addr1 = 16'hFFFF;
    settle();
    check_eq("lat_p1_rd_gnt", {ifb.gnt0, ifb.gnt1}, 2'b01);
    tick();
    ifb.req1 = 1'b0;
    ifb.req0 = 1'b1; ifb.addr0 = 16'h0100;
    settle();
    check_eq("lat_p0_rd0_gnt", {ifb.gnt0, ifb.gnt1}, 2'b10);
    check_eq("lat_rvalid_c1", {ifb.rvalid0, ifb.rvalid1}, 2'b00);
    tick();
    ifb.addr0 = 16'h0101;
    settle();
    check_eq("lat_p0_rd1_gnt", {ifb.gnt0, ifb.gnt1}, 2'b10);
    check_eq("lat_rvalid_c2", {ifb.rvalid0, ifb.rvalid1}, 2'b00);
    tick();
    ifb.req0 = 1'b0;
    settle();
    check_eq("lat_rvalid1", {ifb.rvalid0, ifb.rvalid1}, 2'b01);
    check_eq("lat_rdata1", {24'h0, ifb.rdata1}, 32'h0000_003C);
    tick();
    settle();
    check_eq("lat_rvalid0_a", {ifb.rvalid0, ifb.rvalid1}, 2'b10);
    check_eq("lat_rdata0_a", {24'h0, ifb.rdata0}, 32'h0000_0011);
    tick();
    settle();
    check_eq("lat_rvalid0_b", {ifb.rvalid0, ifb.rvalid1}, 2'b10);
    check_eq("lat_rdata0_b", {24'h0, ifb.rdata0}, 32'h0000_0022);
    tick();
    settle();
    check_eq("lat_rvalid_end", {ifb.rvalid0, ifb.rvalid1}, 2'b00);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
